// File: rtl/axi_lite_pkg.sv
// Shared AXI-lite constants: FSM state encoding, response codes and the
// address map that the bus decoder also uses.
package axi_lite_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WR,
      WR_RESP,
      RD_ADDR,
      RD_DATA,
      RSP
   } state_t;

   localparam logic [2:0] RESP_OKAY    = 3'b000;
   localparam logic [2:0] RESP_SLVERR  = 3'b010;
   // Not a legal AXI code; marks a transaction aborted by the local watchdog.
   localparam logic [2:0] TIMEOUT_RESP = 3'b100;

   localparam logic [7:0] ADDER_BASE = 8'h00;
   localparam logic [7:0] ADDER_MASK = 8'hF0;
   localparam logic [7:0] MULT_BASE  = 8'h10;
   localparam logic [7:0] MULT_MASK  = 8'hF0;

endpackage

// File: rtl/axi_timeout_counter.sv
// Per-phase watchdog: counts enabled cycles, flags expiry on the cycle that brings
// the count to TIMEOUT_CYCLES; zero latency, no backpressure.
module axi_timeout_counter #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= '0;
      else if (clear || !enable)
         cnt <= '0;
      else
         cnt <= cnt + CW'(1);
   end

   assign expired = enable && (cnt == LAST);

endmodule

// File: rtl/axi_lite_cmd_master.sv
// Single-outstanding AXI-lite master: first AXI valid 1 cycle after accept; cmd_ready
// stays low until the response is consumed, and a stalled AXI phase aborts after TIMEOUT_CYCLES.
module axi_lite_cmd_master
   import axi_lite_pkg::*;
#(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 8,
   parameter int RESP_WIDTH     = 3,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                    m0_axi_aclk,
   input  logic                    m0_axi_areset,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic                    cmd_write,
   input  logic [ADDR_WIDTH-1:0]   cmd_addr,
   input  logic [DATA_WIDTH-1:0]   cmd_wdata,
   input  logic [DATA_WIDTH/8:0]   cmd_wstrb,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [DATA_WIDTH-1:0]   rsp_rdata,
   output logic [RESP_WIDTH-1:0]   rsp_resp,
   output logic [ADDR_WIDTH-1:0]   m0_axi_awaddr,
   output logic                    m0_axi_awvalid,
   input  logic                    m0_axi_awready,
   output logic [DATA_WIDTH-1:0]   m0_axi_wdata,
   output logic [DATA_WIDTH/8:0]   m0_axi_wstrb,
   output logic                    m0_axi_wvalid,
   input  logic                    m0_axi_wready,
   input  logic [RESP_WIDTH-1:0]   m0_axi_bresp,
   input  logic                    m0_axi_bvalid,
   output logic                    m0_axi_bready,
   output logic [ADDR_WIDTH-1:0]   m0_axi_araddr,
   output logic                    m0_axi_arvalid,
   input  logic                    m0_axi_arready,
   input  logic [DATA_WIDTH-1:0]   m0_axi_rdata,
   input  logic [RESP_WIDTH-1:0]   m0_axi_rresp,
   input  logic                    m0_axi_rvalid,
   output logic                    m0_axi_rready
);

   state_t state;
   logic   aw_ok, w_ok, leave_wait, tmo_en, tmo;

   // A write channel is "ok" once its handshake is done or completes this cycle.
   assign aw_ok  = !m0_axi_awvalid || m0_axi_awready;
   assign w_ok   = !m0_axi_wvalid  || m0_axi_wready;
   assign tmo_en = (state == WR) || (state == WR_RESP) ||
                   (state == RD_ADDR) || (state == RD_DATA);

   always_comb begin
      leave_wait = 1'b0;
      case (state)
         WR:      leave_wait = aw_ok && w_ok;
         WR_RESP: leave_wait = m0_axi_bvalid && m0_axi_bready;
         RD_ADDR: leave_wait = m0_axi_arvalid && m0_axi_arready;
         RD_DATA: leave_wait = m0_axi_rvalid && m0_axi_rready;
         default: leave_wait = 1'b0;
      endcase
   end

   axi_timeout_counter #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_tmo (
      .clk     (m0_axi_aclk),
      .rst     (m0_axi_areset),
      .clear   (leave_wait),
      .enable  (tmo_en),
      .expired (tmo)
   );

   always_ff @(posedge m0_axi_aclk or posedge m0_axi_areset) begin
      if (m0_axi_areset) begin
         state          <= IDLE;
         cmd_ready      <= 1'b1;
         rsp_valid      <= 1'b0;
         rsp_rdata      <= '0;
         rsp_resp       <= RESP_WIDTH'(RESP_OKAY);
         m0_axi_awaddr  <= '0;
         m0_axi_awvalid <= 1'b0;
         m0_axi_wdata   <= '0;
         m0_axi_wstrb   <= '0;
         m0_axi_wvalid  <= 1'b0;
         m0_axi_bready  <= 1'b0;
         m0_axi_araddr  <= '0;
         m0_axi_arvalid <= 1'b0;
         m0_axi_rready  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (cmd_valid && cmd_ready) begin
                  cmd_ready     <= 1'b0;
                  m0_axi_awaddr <= cmd_addr;
                  m0_axi_araddr <= cmd_addr;
                  m0_axi_wdata  <= cmd_wdata;
                  m0_axi_wstrb  <= cmd_wstrb;
                  if (cmd_write) begin
                     m0_axi_awvalid <= 1'b1;
                     m0_axi_wvalid  <= 1'b1;
                     state          <= WR;
                  end else begin
                     m0_axi_arvalid <= 1'b1;
                     state          <= RD_ADDR;
                  end
               end
            end
            WR: begin
               if (aw_ok && w_ok) begin
                  m0_axi_awvalid <= 1'b0;
                  m0_axi_wvalid  <= 1'b0;
                  m0_axi_bready  <= 1'b1;
                  state          <= WR_RESP;
               end else if (tmo) begin
                  m0_axi_awvalid <= 1'b0;
                  m0_axi_wvalid  <= 1'b0;
                  rsp_resp       <= RESP_WIDTH'(TIMEOUT_RESP);
                  rsp_rdata      <= '0;
                  rsp_valid      <= 1'b1;
                  state          <= RSP;
               end else begin
                  if (m0_axi_awready) m0_axi_awvalid <= 1'b0;
                  if (m0_axi_wready)  m0_axi_wvalid  <= 1'b0;
               end
            end
            WR_RESP: begin
               if (m0_axi_bvalid && m0_axi_bready) begin
                  m0_axi_bready <= 1'b0;
                  rsp_resp      <= m0_axi_bresp;
                  rsp_rdata     <= '0;
                  rsp_valid     <= 1'b1;
                  state         <= RSP;
               end else if (tmo) begin
                  m0_axi_bready <= 1'b0;
                  rsp_resp      <= RESP_WIDTH'(TIMEOUT_RESP);
                  rsp_rdata     <= '0;
                  rsp_valid     <= 1'b1;
                  state         <= RSP;
               end
            end
            RD_ADDR: begin
               if (m0_axi_arvalid && m0_axi_arready) begin
                  m0_axi_arvalid <= 1'b0;
                  m0_axi_rready  <= 1'b1;
                  state          <= RD_DATA;
               end else if (tmo) begin
                  m0_axi_arvalid <= 1'b0;
                  rsp_resp       <= RESP_WIDTH'(TIMEOUT_RESP);
                  rsp_rdata      <= '0;
                  rsp_valid      <= 1'b1;
                  state          <= RSP;
               end
            end
            RD_DATA: begin
               if (m0_axi_rvalid && m0_axi_rready) begin
                  m0_axi_rready <= 1'b0;
                  rsp_rdata     <= m0_axi_rdata;
                  rsp_resp      <= m0_axi_rresp;
                  rsp_valid     <= 1'b1;
                  state         <= RSP;
               end else if (tmo) begin
                  m0_axi_rready <= 1'b0;
                  rsp_resp      <= RESP_WIDTH'(TIMEOUT_RESP);
                  rsp_rdata     <= '0;
                  rsp_valid     <= 1'b1;
                  state         <= RSP;
               end
            end
            RSP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  cmd_ready <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// Directed bench for axi_lite_cmd_master with a hand-driven AXI-lite slave.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_axi_lite_cmd_master;
   import axi_lite_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
   logic [7:0]  cmd_addr = '0;
   logic [31:0] cmd_wdata = '0;
   logic [4:0]  cmd_wstrb = '0;
   logic        rsp_valid, rsp_ready = 1'b0;
   logic [31:0] rsp_rdata;
   logic [2:0]  rsp_resp;
   logic [7:0]  awaddr, araddr;
   logic        awvalid, awready = 1'b0;
   logic [31:0] wdata;
   logic [4:0]  wstrb;
   logic        wvalid, wready = 1'b0;
   logic [2:0]  bresp = '0;
   logic        bvalid = 1'b0, bready;
   logic        arvalid, arready = 1'b0;
   logic [31:0] rdata = '0;
   logic [2:0]  rresp = '0;
   logic        rvalid = 1'b0, rready;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   axi_lite_cmd_master #(
      .DATA_WIDTH(32), .ADDR_WIDTH(8), .RESP_WIDTH(3), .TIMEOUT_CYCLES(16)
   ) dut (
      .m0_axi_aclk(clk), .m0_axi_areset(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
      .m0_axi_awaddr(awaddr), .m0_axi_awvalid(awvalid), .m0_axi_awready(awready),
      .m0_axi_wdata(wdata), .m0_axi_wstrb(wstrb), .m0_axi_wvalid(wvalid), .m0_axi_wready(wready),
      .m0_axi_bresp(bresp), .m0_axi_bvalid(bvalid), .m0_axi_bready(bready),
      .m0_axi_araddr(araddr), .m0_axi_arvalid(arvalid), .m0_axi_arready(arready),
      .m0_axi_rdata(rdata), .m0_axi_rresp(rresp), .m0_axi_rvalid(rvalid), .m0_axi_rready(rready)
   );

   task automatic test_reset();
      repeat (2) @(negedge clk);
      n_checks++;
      if ({cmd_ready, awvalid, wvalid, bready, arvalid, rready, rsp_valid} !== 7'b1000000) begin
         n_fail++;
         $display("FAIL reset_ctrl: got %b expected 1000000",
                  {cmd_ready, awvalid, wvalid, bready, arvalid, rready, rsp_valid});
      end
      n_checks++;
      if ({rsp_rdata, rsp_resp, awaddr, araddr, wdata, wstrb} !== '0) begin
         n_fail++;
         $display("FAIL reset_data: rdata %h resp %b awaddr %h araddr %h wdata %h wstrb %h expected all 0",
                  rsp_rdata, rsp_resp, awaddr, araddr, wdata, wstrb);
      end
      rst = 1'b0;
   endtask

   task automatic test_zero_wait_write();
      @(negedge clk);
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h04;
      cmd_wdata = 32'h0000_0005; cmd_wstrb = 5'h1F;
      awready = 1'b1; wready = 1'b1;
      @(negedge clk);                               // cycle after accept
      cmd_valid = 1'b0;
      n_checks++;
      if ({cmd_ready, awvalid, wvalid, awaddr, wdata, wstrb} !== {1'b0, 1'b1, 1'b1, 8'h04, 32'h5, 5'h1F}) begin
         n_fail++;
         $display("FAIL zw_issue: rdy %b aw %b w %b awaddr %h wdata %h wstrb %h expected 0 1 1 04 00000005 1f",
                  cmd_ready, awvalid, wvalid, awaddr, wdata, wstrb);
      end
      @(negedge clk);                               // both handshakes took the same edge
      n_checks++;
      if ({awvalid, wvalid, bready, rsp_valid} !== 4'b0010) begin
         n_fail++;
         $display("FAIL zw_same_cycle_hs: aw %b w %b bready %b rsp_valid %b expected 0 0 1 0",
                  awvalid, wvalid, bready, rsp_valid);
      end
      awready = 1'b0; wready = 1'b0; bvalid = 1'b1; bresp = RESP_OKAY;
      @(negedge clk);                               // fourth cycle counting the accept cycle
      bvalid = 1'b0;
      n_checks++;
      if ({rsp_valid, bready, rsp_resp, rsp_rdata} !== {1'b1, 1'b0, 3'b000, 32'h0}) begin
         n_fail++;
         $display("FAIL zw_rsp: valid %b bready %b resp %b rdata %h expected 1 0 000 00000000",
                  rsp_valid, bready, rsp_resp, rsp_rdata);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      n_checks++;
      if ({rsp_valid, cmd_ready} !== 2'b01) begin
         n_fail++;
         $display("FAIL zw_return_idle: rsp_valid %b cmd_ready %b expected 0 1", rsp_valid, cmd_ready);
      end
   endtask

   task automatic test_split_write();
      int bhs = 0;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h0C;
      cmd_wdata = 32'h1234_5678; cmd_wstrb = 5'h0F;
      @(negedge clk);
      cmd_valid = 1'b0; wready = 1'b1;
      @(negedge clk);
      wready = 1'b0;
      n_checks++;
      if ({awvalid, wvalid} !== 2'b10) begin
         n_fail++;
         $display("FAIL split_w_first: aw %b w %b expected 1 0", awvalid, wvalid);
      end
      @(negedge clk);
      n_checks++;
      if ({awvalid, wvalid, bready, awaddr} !== {3'b100, 8'h0C}) begin
         n_fail++;
         $display("FAIL split_aw_hold: aw %b w %b bready %b awaddr %h expected 1 0 0 0c",
                  awvalid, wvalid, bready, awaddr);
      end
      awready = 1'b1;
      @(negedge clk);
      awready = 1'b0;
      n_checks++;
      if ({awvalid, wvalid, bready} !== 3'b001) begin
         n_fail++;
         $display("FAIL split_to_bresp: aw %b w %b bready %b expected 0 0 1", awvalid, wvalid, bready);
      end
      // Leave bvalid asserted for several cycles; only one beat may be taken.
      bvalid = 1'b1; bresp = RESP_SLVERR;
      for (int i = 0; i < 3; i++) begin
         if (bvalid && bready) bhs++;
         @(negedge clk);
      end
      bvalid = 1'b0;
      n_checks++;
      if (bhs !== 1) begin
         n_fail++;
         $display("FAIL split_b_count: got %0d handshakes expected 1", bhs);
      end
      n_checks++;
      if ({rsp_valid, rsp_resp, rsp_rdata} !== {1'b1, 3'b010, 32'h0}) begin
         n_fail++;
         $display("FAIL split_rsp: valid %b resp %b rdata %h expected 1 010 00000000",
                  rsp_valid, rsp_resp, rsp_rdata);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
   endtask

   task automatic test_read_delay();
      @(negedge clk);
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h08; arready = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      n_checks++;
      if ({arvalid, araddr, awvalid, wvalid} !== {1'b1, 8'h08, 2'b00}) begin
         n_fail++;
         $display("FAIL rd_issue: ar %b araddr %h aw %b w %b expected 1 08 0 0", arvalid, araddr, awvalid, wvalid);
      end
      @(negedge clk);
      arready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if ({arvalid, rready, rsp_valid} !== 3'b010) begin
            n_fail++;
            $display("FAIL rd_wait_%0d: ar %b rready %b rsp_valid %b expected 0 1 0", i, arvalid, rready, rsp_valid);
         end
         @(negedge clk);
      end
      rvalid = 1'b1; rdata = 32'hDEAD_BEEF; rresp = RESP_OKAY;
      @(negedge clk);
      rvalid = 1'b0; rdata = '0;
      n_checks++;
      if ({rsp_valid, rready, rsp_rdata, rsp_resp} !== {2'b10, 32'hDEADBEEF, 3'b000}) begin
         n_fail++;
         $display("FAIL rd_rsp: valid %b rready %b rdata %h resp %b expected 1 0 deadbeef 000",
                  rsp_valid, rready, rsp_rdata, rsp_resp);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
   endtask

   task automatic test_timeout();
      int n_ar = 0;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h20; arready = 1'b0;
      @(negedge clk);
      cmd_valid = 1'b0;
      for (int i = 0; i < 40 && arvalid; i++) begin
         n_ar++;
         @(negedge clk);
      end
      n_checks++;
      if (n_ar !== 16) begin
         n_fail++;
         $display("FAIL tmo_ar_cycles: arvalid high %0d cycles expected 16", n_ar);
      end
      n_checks++;
      if ({rsp_valid, arvalid, rready, rsp_resp, rsp_rdata} !== {3'b100, 3'b100, 32'h0}) begin
         n_fail++;
         $display("FAIL tmo_rsp: valid %b ar %b rready %b resp %b rdata %h expected 1 0 0 100 00000000",
                  rsp_valid, arvalid, rready, rsp_resp, rsp_rdata);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      n_checks++;
      if ({cmd_ready, rsp_valid} !== 2'b10) begin
         n_fail++;
         $display("FAIL tmo_recover: cmd_ready %b rsp_valid %b expected 1 0", cmd_ready, rsp_valid);
      end
   endtask

   // Also exercises a normal command directly after the timeout recovery.
   task automatic test_backpressure();
      @(negedge clk);
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h14; arready = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({arvalid, araddr} !== {1'b1, 8'h14}) begin
         n_fail++;
         $display("FAIL bp_issue: ar %b araddr %h expected 1 14", arvalid, araddr);
      end
      @(negedge clk);
      arready = 1'b0; rvalid = 1'b1; rdata = 32'hCAFE_F00D; rresp = RESP_OKAY;
      @(negedge clk);
      rvalid = 1'b0; rdata = '0;
      for (int i = 0; i < 5; i++) begin
         n_checks++;
         if ({rsp_valid, cmd_ready, awvalid, wvalid, arvalid, rready, rsp_rdata, rsp_resp}
             !== {6'b100000, 32'hCAFEF00D, 3'b000}) begin
            n_fail++;
            $display("FAIL bp_hold_%0d: valid %b rdy %b aw %b w %b ar %b rready %b rdata %h resp %b expected 1 0 0 0 0 0 cafef00d 000",
                     i, rsp_valid, cmd_ready, awvalid, wvalid, arvalid, rready, rsp_rdata, rsp_resp);
         end
         @(negedge clk);
      end
      rsp_ready = 1'b1; cmd_valid = 1'b0;
      @(negedge clk);
      rsp_ready = 1'b0;
      n_checks++;
      if ({cmd_ready, rsp_valid, arvalid} !== 3'b100) begin
         n_fail++;
         $display("FAIL bp_release: cmd_ready %b rsp_valid %b ar %b expected 1 0 0", cmd_ready, rsp_valid, arvalid);
      end
   endtask

   task automatic test_reset_mid();
      int n_rsp = 0;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h30;
      cmd_wdata = 32'hA5A5_0001; cmd_wstrb = 5'h1F;
      awready = 1'b1; wready = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      @(negedge clk);
      awready = 1'b0; wready = 1'b0;
      n_checks++;
      if (bready !== 1'b1) begin
         n_fail++;
         $display("FAIL rstmid_in_wr_resp: bready %b expected 1", bready);
      end
      #1 rst = 1'b1;
      #1;
      n_checks++;
      if ({awvalid, wvalid, bready, arvalid, rready, rsp_valid, cmd_ready} !== 7'b0000001) begin
         n_fail++;
         $display("FAIL rstmid_async: aw %b w %b b %b ar %b r %b rsp %b rdy %b expected 0 0 0 0 0 0 1",
                  awvalid, wvalid, bready, arvalid, rready, rsp_valid, cmd_ready);
      end
      @(negedge clk);
      rst = 1'b0; bvalid = 1'b1; bresp = RESP_OKAY;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (rsp_valid) n_rsp++;
      end
      bvalid = 1'b0;
      n_checks++;
      if ({n_rsp, cmd_ready, bready} !== {32'd0, 2'b10}) begin
         n_fail++;
         $display("FAIL rstmid_after: rsp_valid cycles %0d cmd_ready %b bready %b expected 0 1 0",
                  n_rsp, cmd_ready, bready);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_zero_wait_write();
      test_split_write();
      test_read_delay();
      test_timeout();
      test_backpressure();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/axi_lite_cmd_master.md
Name: axi_lite_cmd_master

Overview:
- Upstream AXI-lite master that drives the wrapper's s3 slave port, and through it the bus, adder and multiplier.
- Accepts one command at a time on a simple valid/ready command port and runs one AXI-lite write or read.
- Returns data and response on a response port.
- Includes a per-transaction timeout so a hung slave cannot stall the testbench or the upstream controller.

Parameters:
- DATA_WIDTH, 32, data bus width.
- ADDR_WIDTH, 8, address width.
- RESP_WIDTH, 3, response field width, matching the bus.
- TIMEOUT_CYCLES, 255, maximum cycles spent waiting in any single AXI phase before the transaction aborts.

Ports:
- m0_axi_aclk  in  1  clock
- m0_axi_areset  in  1  asynchronous active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_WIDTH  target address
- cmd_wdata  in  DATA_WIDTH  write data
- cmd_wstrb  in  DATA_WIDTH/8+1  write strobes, forwarded unchanged
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed
- rsp_rdata  out  DATA_WIDTH  read data (0 for writes)
- rsp_resp  out  RESP_WIDTH  bresp/rresp, or TIMEOUT_RESP
- m0_axi_awaddr  out  ADDR_WIDTH; m0_axi_awvalid  out  1; m0_axi_awready  in  1
- m0_axi_wdata  out  DATA_WIDTH; m0_axi_wstrb  out  DATA_WIDTH/8+1; m0_axi_wvalid  out  1; m0_axi_wready  in  1
- m0_axi_bresp  in  RESP_WIDTH; m0_axi_bvalid  in  1; m0_axi_bready  out  1
- m0_axi_araddr  out  ADDR_WIDTH; m0_axi_arvalid  out  1; m0_axi_arready  in  1
- m0_axi_rdata  in  DATA_WIDTH; m0_axi_rresp  in  RESP_WIDTH; m0_axi_rvalid  in  1; m0_axi_rready  out  1

Behaviour:
- Reset (asynchronous, active-high):
  - All outputs are registered and reset to 0, except cmd_ready, which resets to 1.
  - FSM goes to IDLE and the timeout counter clears.
  - Reset mid-transaction aborts immediately; no response is produced.
- States: IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, RSP.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid&cmd_ready, latch addr/wdata/wstrb/write and drop cmd_ready.
  - Next cycle enter WR with awvalid = wvalid = 1, or RD_ADDR with arvalid = 1.
  - Latency from accept to first valid: 1 cycle.
- WR:
  - awvalid and wvalid each clear independently on their own handshake.
  - Both handshakes may occur in the same cycle or in either order.
  - When both have completed, go to WR_RESP with bready = 1.
  - Payload stays stable while the matching valid is high.
- WR_RESP:
  - On bvalid&bready, capture bresp, set rsp_rdata = 0, clear bready, go to RSP.
- RD_ADDR:
  - On arvalid&arready, clear arvalid, set rready = 1, go to RD_DATA.
- RD_DATA:
  - On rvalid&rready, capture rdata and rresp, clear rready, go to RSP.
- RSP:
  - rsp_valid = 1; rsp_rdata and rsp_resp are held stable.
  - On rsp_ready, clear rsp_valid, set cmd_ready = 1, return to IDLE.
  - Minimum accept-to-accept spacing with a zero-wait slave: 4 cycles.
- Timeout:
  - Counter clears on every state entry and increments each cycle in WR, WR_RESP, RD_ADDR and RD_DATA.
  - On reaching TIMEOUT_CYCLES, deassert all AXI valids/readies, set rsp_resp = TIMEOUT_RESP and rsp_rdata = 0, go to RSP.
  - A handshake completing in the same cycle the counter reaches TIMEOUT_CYCLES wins; no timeout is raised.
  - Abort is a deliberate AXI rule break, used only for debug/test recovery.
- Only one outstanding transaction at a time; cmd_valid is ignored while cmd_ready = 0.
- Response values are passed through unmodified; no response decoding is done.

Decomposition:
- Package axi_lite_pkg holds:
  - state enum;
  - RESP_OKAY = 3'b000 and RESP_SLVERR = 3'b010;
  - TIMEOUT_RESP = 3'b100;
  - address constants for the adder and multiplier regions, shared with the bus decoder.
- One natural sub-module, axi_timeout_counter: clear, enable, TIMEOUT_CYCLES parameter, expired output.
- FSM and datapath registers stay in the top module.

Test Plan:
- Zero-wait write: addr 0x04, data 0x0000_0005, wstrb all ones.
  - Required: aw and w handshakes on the same cycle; bresp 0; rsp_valid 4 cycles after accept with rsp_resp = 0 and rsp_rdata = 0.
- Read with rvalid delayed 3 cycles: addr 0x08, slave returns 0xDEAD_BEEF.
  - Required: rready held high throughout the delay; rsp_rdata = 0xDEADBEEF, rsp_resp = 0.
- Split write handshakes: wready 2 cycles before awready.
  - Required: wvalid drops after its own handshake; awvalid holds until awready; exactly one bvalid handshake.
- Timeout: slave never asserts arready, TIMEOUT_CYCLES = 16.
  - Required: arvalid drops after 16 cycles; rsp_resp = 3'b100; rsp_rdata = 0; next command is accepted normally.
- Backpressure on the response port: rsp_ready held low 5 cycles, with cmd_valid high throughout.
  - Required: rsp stays stable, cmd_ready stays 0, no new AXI valid asserted.
- Reset asserted while in WR_RESP.
  - Required: all AXI valids/readies go 0 asynchronously, cmd_ready = 1 after release, no rsp_valid pulse.
